// File: rtl/bit_reverse.sv
// bit_reverse: registered bit-order reverser with valid/ready handshake.
// Modes: 00 full reverse, 01 nibble reverse, 10 pass-through, 11 pair swap.
// Optional macro BIT_REVERSE_PARITY_EN adds a registered parity output rev_par.
// WIDTH must be a multiple of 4 and at least 4.
module bit_reverse #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rev_in,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] rev_out,
    output logic             out_valid,
    input  logic             out_ready
`ifdef BIT_REVERSE_PARITY_EN
    ,
    output logic             rev_par
`endif
);

    localparam int NumNibbles = WIDTH / 4;
    localparam int NumPairs   = WIDTH / 2;

    typedef enum logic [1:0] {
        ModeFull   = 2'b00,
        ModeNibble = 2'b01,
        ModePass   = 2'b10,
        ModePair   = 2'b11
    } revMode_e;

    logic [WIDTH-1:0] fullRev;
    logic [WIDTH-1:0] nibbleRev;
    logic [WIDTH-1:0] pairRev;
    logic [WIDTH-1:0] revOut_d;
    logic [WIDTH-1:0] revOut_q;
    logic             outValid_d;
    logic             outValid_q;
    logic             inFire;
    logic             outFire;

    // The stage is free when it is empty or its current result is leaving.
    assign in_ready = !outValid_q | out_ready;
    assign inFire   = in_valid & in_ready;
    assign outFire  = outValid_q & out_ready;

    // Whole-word mirror: bit i takes bit WIDTH-1-i.
    always_comb begin
        fullRev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fullRev[i] = rev_in[WIDTH-1-i];
        end
    end

    // Mirror inside each 4-bit group while keeping the group order.
    always_comb begin
        nibbleRev = '0;
        for (int g = 0; g < NumNibbles; g++) begin
            for (int k = 0; k < 4; k++) begin
                nibbleRev[4*g+k] = rev_in[4*g+3-k];
            end
        end
    end

    // Swap the two bits of every 2-bit group.
    always_comb begin
        pairRev = '0;
        for (int p = 0; p < NumPairs; p++) begin
            pairRev[2*p]   = rev_in[2*p+1];
            pairRev[2*p+1] = rev_in[2*p];
        end
    end

    // Select the new result; it only lands in the register on an input transfer.
    always_comb begin
        revOut_d = revOut_q;
        if (inFire) begin
            case (revMode_e'(mode))
                ModeFull:   revOut_d = fullRev;
                ModeNibble: revOut_d = nibbleRev;
                ModePass:   revOut_d = rev_in;
                ModePair:   revOut_d = pairRev;
                default:    revOut_d = rev_in;
            endcase
        end
    end

    // A new word keeps the stage full; a lone output transfer empties it.
    always_comb begin
        outValid_d = outValid_q;
        if (inFire) begin
            outValid_d = 1'b1;
        end else if (outFire) begin
            outValid_d = 1'b0;
        end
    end

    // Result and valid registers; reset wins over any transfer in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            revOut_q   <= '0;
            outValid_q <= 1'b0;
        end else begin
            revOut_q   <= revOut_d;
            outValid_q <= outValid_d;
        end
    end

    assign rev_out   = revOut_q;
    assign out_valid = outValid_q;

`ifdef BIT_REVERSE_PARITY_EN
    logic revPar_d;
    logic revPar_q;

    // Parity tracks the result register, so it updates and holds with it.
    always_comb begin
        revPar_d = revPar_q;
        if (inFire) begin
            revPar_d = ^revOut_d;
        end
    end

    // Parity register, cleared alongside the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            revPar_q <= 1'b0;
        end else begin
            revPar_q <= revPar_d;
        end
    end

    assign rev_par = revPar_q;
`endif

endmodule

// File: tb/tb_bit_reverse.sv
// Testbench for bit_reverse: directed test-plan steps followed by a random
// stream, all compared against a behavioural model of the handshake stage.
// Honours BIT_REVERSE_PARITY_EN when the design is built with it.
module tb_bit_reverse;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] rev_in;
    logic [1:0]   mode;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] rev_out;
    logic         out_valid;
    logic         out_ready;
`ifdef BIT_REVERSE_PARITY_EN
    logic         rev_par;
`endif

    int           testCount;
    int           failCount;

    logic         modelValid;
    logic [W-1:0] modelData;
    logic         sampledReady;

    bit_reverse #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rev_in    (rev_in),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rev_out   (rev_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef BIT_REVERSE_PARITY_EN
        ,
        .rev_par   (rev_par)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Each mode reverses bit order inside groups of a given size:
    // full = one group of W, nibble = 4, pass = 1, pair = 2.
    function automatic logic [W-1:0] refRev(input logic [W-1:0] d, input logic [1:0] m);
        logic [W-1:0] r;
        int           g;
        case (m)
            2'd0:    g = W;
            2'd1:    g = 4;
            2'd2:    g = 1;
            default: g = 2;
        endcase
        r = '0;
        for (int i = 0; i < W; i++) begin
            r[i] = d[(i / g) * g + (g - 1) - (i % g)];
        end
        return r;
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Compare the registered outputs against the model state.
    task automatic checkOutput(input string tag);
        checkEq({tag, "_valid"}, {31'd0, out_valid}, {31'd0, modelValid});
        checkEq({tag, "_data"}, {24'd0, rev_out}, {24'd0, modelData});
`ifdef BIT_REVERSE_PARITY_EN
        checkEq({tag, "_par"}, {31'd0, rev_par}, {31'd0, 1'($countones(modelData) % 2)});
`endif
    endtask

    // Drive one cycle of inputs, check in_ready, clock, advance the model, check outputs.
    task automatic applyStimulus(input string tag, input logic r, input logic iv,
                                 input logic [W-1:0] d, input logic [1:0] m, input logic ordy);
        logic expReady;
        rst       = r;
        in_valid  = iv;
        rev_in    = d;
        mode      = m;
        out_ready = ordy;
        #1;
        expReady     = !modelValid || ordy;
        sampledReady = in_ready;
        checkEq({tag, "_ready"}, {31'd0, in_ready}, {31'd0, expReady});
        @(posedge clk);
        if (r) begin
            modelValid = 1'b0;
            modelData  = '0;
        end else if (iv && expReady) begin
            modelValid = 1'b1;
            modelData  = refRev(d, m);
        end else if (modelValid && ordy) begin
            modelValid = 1'b0;
        end
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic         rr;
        logic         rv;
        logic         ro;
        logic [W-1:0] rd;
        logic [1:0]   rm;

        testCount  = 0;
        failCount  = 0;
        modelValid = 1'b0;
        modelData  = '0;
        rst = 1'b1; in_valid = 1'b0; rev_in = '0; mode = 2'b00; out_ready = 1'b0;

        // Reset state
        applyStimulus("reset", 1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
        checkEq("reset_valid_lit", {31'd0, out_valid}, 32'd0);
        checkEq("reset_data_lit", {24'd0, rev_out}, 32'd0);

        // Mode 00 examples, streamed back to back with no bubbles
        applyStimulus("full0", 1'b0, 1'b1, 8'b10000000, 2'b00, 1'b1);
        checkEq("full0_lit", {24'd0, rev_out}, {24'd0, 8'b00000001});
        checkEq("stream0_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus("full1", 1'b0, 1'b1, 8'b11110000, 2'b00, 1'b1);
        checkEq("full1_lit", {24'd0, rev_out}, {24'd0, 8'b00001111});
        checkEq("stream1_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus("full2", 1'b0, 1'b1, 8'b11010100, 2'b00, 1'b1);
        checkEq("full2_lit", {24'd0, rev_out}, {24'd0, 8'b00101011});
        checkEq("stream2_valid", {31'd0, out_valid}, 32'd1);
`ifdef BIT_REVERSE_PARITY_EN
        checkEq("par_d4_lit", {31'd0, rev_par}, 32'd0);
`endif
        applyStimulus("full3", 1'b0, 1'b1, 8'b10000011, 2'b00, 1'b1);
        checkEq("full3_lit", {24'd0, rev_out}, {24'd0, 8'b11000001});
        checkEq("stream3_valid", {31'd0, out_valid}, 32'd1);
`ifdef BIT_REVERSE_PARITY_EN
        checkEq("par_83_lit", {31'd0, rev_par}, 32'd1);
`endif

        // Other modes on 11010100
        applyStimulus("mode01", 1'b0, 1'b1, 8'b11010100, 2'b01, 1'b1);
        checkEq("mode01_lit", {24'd0, rev_out}, {24'd0, 8'b10110010});
        applyStimulus("mode10", 1'b0, 1'b1, 8'b11010100, 2'b10, 1'b1);
        checkEq("mode10_lit", {24'd0, rev_out}, {24'd0, 8'b11010100});
        applyStimulus("mode11", 1'b0, 1'b1, 8'b11010100, 2'b11, 1'b1);
        checkEq("mode11_lit", {24'd0, rev_out}, {24'd0, 8'b11101000});

        // Drain, then backpressure with a pending input
        applyStimulus("drain", 1'b0, 1'b0, 8'h00, 2'b00, 1'b1);
        checkEq("drain_valid_lit", {31'd0, out_valid}, 32'd0);
        applyStimulus("bp_load", 1'b0, 1'b1, 8'b11110000, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("bp_hold", 1'b0, 1'b1, 8'b10000000, 2'b01, 1'b0);
            checkEq("bp_ready_lit", {31'd0, sampledReady}, 32'd0);
            checkEq("bp_data_lit", {24'd0, rev_out}, {24'd0, 8'b00001111});
        end
        applyStimulus("bp_release", 1'b0, 1'b1, 8'b10000000, 2'b00, 1'b1);
        checkEq("bp_release_lit", {24'd0, rev_out}, {24'd0, 8'b00000001});

        // Reset mid-stream with in_valid high: nothing captured
        applyStimulus("mid_rst", 1'b1, 1'b1, 8'b00110101, 2'b00, 1'b1);
        checkEq("mid_rst_valid_lit", {31'd0, out_valid}, 32'd0);
        checkEq("mid_rst_data_lit", {24'd0, rev_out}, 32'd0);
        applyStimulus("post_rst", 1'b0, 1'b0, 8'h00, 2'b00, 1'b1);
        checkEq("post_rst_valid_lit", {31'd0, out_valid}, 32'd0);

        // Random traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            rr = ($urandom_range(0, 31) == 0);
            rv = ($urandom_range(0, 3) != 0);
            ro = ($urandom_range(0, 2) != 0);
            rd = W'($urandom);
            rm = 2'($urandom_range(0, 3));
            applyStimulus("rand", rr, rv, rd, rm, ro);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
